// File: rtl/complex_alu_sched_pkg.sv
// Shared opcode, DSP control-bundle definitions and decode helper for the
// complex_alu issue scheduler.
package complex_alu_sched_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;
    localparam logic [2:0] OP_MAX    = 3'b111;

    localparam logic [6:0] OPMODE_MUL  = 7'h05;
    localparam logic [6:0] OPMODE_MULC = 7'h35;
    localparam logic [3:0] ALUMODE_ADD = 4'h0;
    localparam logic [4:0] INMODE_A2B2 = 5'h00;

    // Four DSP cores per field, core_1 in the most significant slice.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [15:0] alumode;
        logic [19:0] inmode;
        logic [27:0] opmode;
        logic [3:0]  cea2;
        logic [3:0]  ceb2;
        logic [3:0]  usemult;
    } alu_bundle_t;

    localparam alu_bundle_t NOP_BUNDLE = '0;

    function automatic logic op_legal(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic alu_bundle_t decode_op(input logic [2:0] op);
        alu_bundle_t b;
        b = NOP_BUNDLE;
        if (op_legal(op)) begin
            b.opcode  = op;
            b.alumode = {4{ALUMODE_ADD}};
            b.inmode  = {4{INMODE_A2B2}};
            b.cea2    = 4'hF;
            b.ceb2    = 4'hF;
            b.usemult = 4'hF;
            // Accumulating ops chain the product into the C port on cores 1 and 3.
            if (op == OP_MULADD || op == OP_MULSUB)
                b.opmode = {OPMODE_MULC, OPMODE_MUL, OPMODE_MULC, OPMODE_MUL};
            else
                b.opmode = {4{OPMODE_MUL}};
        end
        return b;
    endfunction

endpackage

// File: rtl/complex_alu_sched_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a push and
// pop in the same cycle on a full FIFO are both accepted.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~w_full | w_pop);
    assign dout   = r_mem[r_rd];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + PTR_ONE;
            if (w_pop)
                r_rd <= r_rd + PTR_ONE;
            if (w_push && !w_pop)
                r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_ONE;
        end
    end

endmodule

// File: rtl/complex_alu_sched.sv
// Issue controller and result buffer for one complex_alu: decodes opcodes,
// skews operands, tracks in-flight ops and buffers results under credit control.
module complex_alu_sched
    import complex_alu_sched_pkg::*;
#(
    parameter int ALU_LATENCY   = 7,
    parameter int OPERAND_DELAY = 2,
    parameter int RES_DEPTH     = 8,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_opcode,
    input  logic [31:0]          in_din_1,
    input  logic [31:0]          in_din_2,
    input  logic [31:0]          in_din_3,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [2:0]           alu_opcode,
    output logic [15:0]          alu_alumode,
    output logic [19:0]          alu_inmode,
    output logic [27:0]          alu_opmode,
    output logic [3:0]           alu_cea2,
    output logic [3:0]           alu_ceb2,
    output logic [3:0]           alu_usemult,
    output logic [31:0]          alu_din_1,
    output logic [31:0]          alu_din_2,
    output logic [31:0]          alu_din_3,
    input  logic [31:0]          alu_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_err,
    output logic                 busy
);
    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int FW    = 32 + TAG_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                 r_rdy_en;
    logic [CNT_W-1:0]     r_inflight;
    logic [ALU_LATENCY-1:0] r_pv;
    logic [ALU_LATENCY-1:0] r_perr;
    logic [TAG_WIDTH-1:0] r_ptag [ALU_LATENCY];
    logic [95:0]          r_opd  [OPERAND_DELAY];

    logic                 w_issue;
    alu_bundle_t          w_bundle;
    logic                 w_tail_v;
    logic                 w_tail_err;
    logic [FW-1:0]        w_fifo_din;
    logic [FW-1:0]        w_fifo_dout;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;

    // Every in-flight op owns a FIFO slot, so a tail write can never overflow.
    assign in_ready = r_rdy_en && ((r_inflight + w_fifo_count) < CNT_W'(RES_DEPTH));
    assign w_issue  = in_valid & in_ready;
    assign w_bundle = w_issue ? decode_op(in_opcode) : NOP_BUNDLE;

    assign alu_opcode  = w_bundle.opcode;
    assign alu_alumode = w_bundle.alumode;
    assign alu_inmode  = w_bundle.inmode;
    assign alu_opmode  = w_bundle.opmode;
    assign alu_cea2    = w_bundle.cea2;
    assign alu_ceb2    = w_bundle.ceb2;
    assign alu_usemult = w_bundle.usemult;
    assign {alu_din_1, alu_din_2, alu_din_3} = r_opd[OPERAND_DELAY-1];

    assign w_tail_v   = r_pv[ALU_LATENCY-1];
    assign w_tail_err = r_perr[ALU_LATENCY-1];
    assign w_fifo_din = {(w_tail_err ? 32'h0 : alu_dout), r_ptag[ALU_LATENCY-1], w_tail_err};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy_en   <= 1'b0;
            r_inflight <= '0;
            r_pv       <= '0;
            r_perr     <= '0;
            for (int i = 0; i < ALU_LATENCY; i++)
                r_ptag[i] <= '0;
            for (int i = 0; i < OPERAND_DELAY; i++)
                r_opd[i] <= '0;
        end else begin
            r_rdy_en  <= 1'b1;
            r_pv[0]   <= w_issue;
            r_perr[0] <= w_issue & ~op_legal(in_opcode);
            r_ptag[0] <= in_tag;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_perr[i] <= r_perr[i-1];
                r_ptag[i] <= r_ptag[i-1];
            end
            r_opd[0] <= w_issue ? {in_din_1, in_din_2, in_din_3} : 96'h0;
            for (int i = 1; i < OPERAND_DELAY; i++)
                r_opd[i] <= r_opd[i-1];
            unique case ({w_issue, w_tail_v})
                2'b10:   r_inflight <= r_inflight + CNT_ONE;
                2'b01:   r_inflight <= r_inflight - CNT_ONE;
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tail_v),
        .din   (w_fifo_din),
        .pop   (out_valid & out_ready),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign out_valid = ~w_fifo_empty;
    assign {out_data, out_tag, out_err} = w_fifo_dout;
    assign busy = (r_inflight != '0) | ~w_fifo_empty;

endmodule

// File: tb/tb_complex_alu_sched.sv
// Self-checking bench for complex_alu_sched: decode table, latency, ordering,
// backpressure credits, illegal opcodes, operand skew and mid-operation reset.
module tb_complex_alu_sched;
    localparam int LAT = 7;
    localparam int OD  = 2;
    localparam int DEP = 8;
    localparam int TW  = 4;
    localparam logic [27:0] OPM_ALL05 = 28'h0A14285;
    localparam logic [27:0] OPM_MULC  = 28'h6A15A85;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_opcode = '0;
    logic [31:0]   in_din_1 = '0, in_din_2 = '0, in_din_3 = '0;
    logic [TW-1:0] in_tag = '0;
    logic [2:0]    alu_opcode;
    logic [15:0]   alu_alumode;
    logic [19:0]   alu_inmode;
    logic [27:0]   alu_opmode;
    logic [3:0]    alu_cea2, alu_ceb2, alu_usemult;
    logic [31:0]   alu_din_1, alu_din_2, alu_din_3;
    logic [31:0]   alu_dout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic          busy;

    always #5 clk = ~clk;

    complex_alu_sched #(
        .ALU_LATENCY(LAT), .OPERAND_DELAY(OD), .RES_DEPTH(DEP), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_din_1(in_din_1), .in_din_2(in_din_2),
        .in_din_3(in_din_3), .in_tag(in_tag), .alu_opcode(alu_opcode),
        .alu_alumode(alu_alumode), .alu_inmode(alu_inmode), .alu_opmode(alu_opmode),
        .alu_cea2(alu_cea2), .alu_ceb2(alu_ceb2), .alu_usemult(alu_usemult),
        .alu_din_1(alu_din_1), .alu_din_2(alu_din_2), .alu_din_3(alu_din_3),
        .alu_dout(alu_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err), .busy(busy)
    );

    // External ALU stand-in: result of the operands seen at its input appears
    // LAT-OD cycles later, i.e. LAT cycles after the opcode.
    logic [31:0] alu_pipe [LAT-OD];
    initial for (int i = 0; i < LAT-OD; i++) alu_pipe[i] = '0;
    always @(posedge clk) begin
        alu_pipe[0] <= (alu_din_1 + alu_din_2) ^ alu_din_3;
        for (int i = 1; i < LAT-OD; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_dout = alu_pipe[LAT-OD-1];

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: sampled mid-cycle, a pop happens at the next rising edge.
    always @(negedge clk) begin
        #3;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_result: got tag %0h data %0h expected none", out_tag, out_data);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_tag",  out_tag,  mon_e.tag);
                check("out_err",  out_err,  mon_e.err);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3, input logic [TW-1:0] tag, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = op; in_din_1 = d1; in_din_2 = d2; in_din_3 = d3; in_tag = tag;
        #1;
        acc = in_ready;
        if (acc) begin
            e.data = op[2] ? ((d1 + d2) ^ d3) : 32'h0;
            e.tag  = tag;
            e.err  = ~op[2];
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_opcode = '0; in_din_1 = '0; in_din_2 = '0; in_din_3 = '0;
        #1;
    endtask

    task automatic drain(input string name, input int lim);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < lim) begin
            idle();
            n++;
        end
        check(name, (n < lim), 1'b1);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [31:0]   d1, d2, d3;
        logic [TW-1:0] tag;
        logic [2:0]    e_opc;
        logic [27:0]   e_opm;
        logic [3:0]    e_ce;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n, idx;
        logic [31:0] a1, b1, c1, a2, b2, c2;

        tbl[0] = '{3'b100, 32'h0001_0002, 32'h0003_0004, 32'h0000_0010, 4'h1, 3'b100, OPM_ALL05, 4'hF};
        tbl[1] = '{3'b101, 32'h1111_0000, 32'h0000_2222, 32'h0F0F_0F0F, 4'h2, 3'b101, OPM_MULC,  4'hF};
        tbl[2] = '{3'b110, 32'hFFFF_0001, 32'h0002_FFFF, 32'h1234_5678, 4'h3, 3'b110, OPM_MULC,  4'hF};
        tbl[3] = '{3'b111, 32'h7FFF_8000, 32'h8000_7FFF, 32'h0000_0000, 4'h4, 3'b111, OPM_ALL05, 4'hF};
        tbl[4] = '{3'b000, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0001, 4'h5, 3'b000, 28'h0,     4'h0};
        tbl[5] = '{3'b001, 32'h0000_0007, 32'h0000_0009, 32'h0000_0003, 4'h6, 3'b000, 28'h0,     4'h0};
        tbl[6] = '{3'b010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_0000, 4'h7, 3'b000, 28'h0,     4'h0};
        tbl[7] = '{3'b011, 32'h0101_0101, 32'h1010_1010, 32'hFFFF_FFFF, 4'h8, 3'b000, 28'h0,     4'h0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_bundle", {alu_opcode, alu_opmode, alu_usemult, alu_cea2, alu_ceb2}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_in_ready_same", in_ready, 1'b0);
        idle();
        check("release_in_ready_next", in_ready, 1'b1);

        // Decode table, issued back to back
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].tag, acc);
            check("tbl_accept",  acc,         1'b1);
            check("tbl_opcode",  alu_opcode,  tbl[i].e_opc);
            check("tbl_opmode",  alu_opmode,  tbl[i].e_opm);
            check("tbl_usemult", alu_usemult, tbl[i].e_ce);
            check("tbl_cea_ceb", {alu_cea2, alu_ceb2}, {tbl[i].e_ce, tbl[i].e_ce});
            check("tbl_alu_inm", {alu_alumode, alu_inmode}, '0);
        end
        idle();
        drain("tbl_drain", 60);

        // Single MUL latency
        issue(3'b100, 32'h4000_0000, 32'h4000_0000, 32'h0, 4'h3, acc);
        check("mul_accept",  acc,         1'b1);
        check("mul_opmode",  alu_opmode,  OPM_ALL05);
        check("mul_usemult", alu_usemult, 4'hF);
        n = 0;
        do begin
            idle();
            n++;
        end while (!out_valid && n < 20);
        check("mul_latency", n, LAT + 1);
        drain("mul_drain", 30);

        // 8 back-to-back MULADD
        for (int t = 0; t < 8; t++) begin
            issue(3'b101, $urandom, $urandom, $urandom, TW'(t), acc);
            check("muladd_ready",  acc,        1'b1);
            check("muladd_opmode", alu_opmode, OPM_MULC);
        end
        n = 0;
        while (!out_valid && n < 20) begin idle(); n++; end
        n = 0;
        while (out_valid && n < 12) begin idle(); n++; end
        check("muladd_no_gaps", n, 8);
        drain("muladd_drain", 30);

        // Backpressure: 12 offered with out_ready low
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            issue(3'b100, $urandom, $urandom, 32'(idx), TW'(idx), acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, DEP);
        check("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        n = 0;
        while (idx < 12 && n < 40) begin
            issue(3'b100, $urandom, $urandom, 32'(idx), TW'(idx), acc);
            if (acc) idx++;
            n++;
        end
        check("bp_all_accepted", idx, 12);
        idle();
        drain("bp_drain", 60);

        // Illegal opcode between legal neighbours
        issue(3'b100, 32'h0000_1000, 32'h0000_2000, 32'h0, 4'h4, acc);
        issue(3'b010, 32'h1234_0000, 32'h0000_5678, 32'h9, 4'h5, acc);
        check("ill_accept", acc, 1'b1);
        check("ill_bundle", {alu_opcode, alu_opmode, alu_usemult, alu_cea2, alu_ceb2}, '0);
        issue(3'b111, 32'h0003_0000, 32'h0000_0004, 32'h5, 4'h6, acc);
        idle();
        drain("ill_drain", 30);

        // MAX then MULSUB: operand skew
        a1 = 32'h1111_2222; b1 = 32'h3333_4444; c1 = 32'h5555_6666;
        a2 = 32'h7777_8888; b2 = 32'h9999_AAAA; c2 = 32'hBBBB_CCCC;
        issue(3'b111, a1, b1, c1, 4'h1, acc);
        check("skew_opc_max", alu_opcode, 3'b111);
        issue(3'b110, a2, b2, c2, 4'h2, acc);
        check("skew_opc_mulsub", alu_opcode, 3'b110);
        check("skew_opm_mulsub", alu_opmode, OPM_MULC);
        check("skew_din_early", alu_din_1, 32'h0);
        idle();
        check("skew_din_max", {alu_din_1, alu_din_2, alu_din_3}, {a1, b1, c1});
        idle();
        check("skew_din_mulsub", {alu_din_1, alu_din_2, alu_din_3}, {a2, b2, c2});
        idle();
        check("skew_din_after", alu_din_1, 32'h0);
        drain("skew_drain", 30);

        // Reset mid-operation
        issue(3'b100, 32'hA0A0_A0A0, 32'h1, 32'h2, 4'h9, acc);
        issue(3'b101, 32'hB0B0_B0B0, 32'h3, 32'h4, 4'hA, acc);
        issue(3'b110, 32'hC0C0_C0C0, 32'h5, 32'h6, 4'hB, acc);
        idle();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        sb.delete();
        #1;
        check("mrst_din",       alu_din_1, 32'h0);
        check("mrst_busy",      busy,      1'b0);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_in_ready",  in_ready,  1'b0);
        check("mrst_opcode",    alu_opcode, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        idle();
        check("mrst_ready_after", in_ready, 1'b1);
        n = 0;
        for (int c = 0; c < 15; c++) begin
            idle();
            if (out_valid) n++;
        end
        check("mrst_no_stale", n, 0);
        check("mrst_busy_after", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
